// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
//   md_op_t    : operation codes issued by the CPU decode stage
//   md_state_t : sequencing states of the iterative datapath
//   DIV0_LO    : LO value produced by a divide by zero (slice to WIDTH)
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } md_state_t;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

  function automatic logic is_arith(input md_op_t o);
    return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic is_div(input md_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational radix-2 step shared by multiply and divide.
//   mode_div : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in   : multiply {partial_hi, multiplier_remaining}
//              divide   {remainder, dividend_remaining/quotient}
//   operand  : multiplicand (multiply) or divisor (divide), unsigned
//   acc_out  : accumulator after this step
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Carry out of the add is kept: it becomes the new top bit after the shift.
  assign sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
  // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
  assign diff   = rem_sh - {1'b0, operand};

  always_comb begin
    acc_out = acc_in;
    if (mode_div) begin
      if (!diff[WIDTH]) acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else              acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_in[0]) acc_out = {sum, acc_in[WIDTH-1:1]};
      else           acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
//
//   state | meaning
//   IDLE  | waiting; MTHI/MTLO write HI/LO directly, arith ops are accepted
//   PREP  | take operand magnitudes, record result signs, load step counter
//   RUN   | ITER_PER_CYCLE radix-2 steps per cycle until the counter hits 1
//   FIX   | apply signs / divide-by-zero result, write HI/LO, pulse done
//
// Ports:
//   clk, reset (async, active-high), clock_enable (gates every flop)
//   start/op/op_a/op_b : request from the CPU register-read stage
//   busy : arithmetic op in flight (CPU stalls)
//   done : one-cycle pulse, HI/LO already updated
//   hi/lo: architectural HI/LO registers
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int STEPS = WIDTH / ITER_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t          state_q, state_d;
  md_op_t             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;        // original rs, kept for divide by zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // rt, then the unsigned step operand
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] chain [ITER_PER_CYCLE+1];

  assign op_div    = is_div(op_q);
  assign op_signed = is_signed_op(op_q);
  assign a_mag     = (op_signed && a_q[WIDTH-1])    ? -a_q    : a_q;
  assign b_mag     = (op_signed && opnd_q[WIDTH-1]) ? -opnd_q : opnd_q;
  assign quot_fix  = quot_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rem_neg_q  ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix  = quot_neg_q ? -acc_q : acc_q;

  assign chain[0] = acc_q;
  for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_div (op_div),
      .acc_in   (chain[g]),
      .operand  (opnd_q),
      .acc_out  (chain[g+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_arith(op)) begin
            op_d    = op;
            a_d     = op_a;
            opnd_d  = op_b;
            busy_d  = 1'b1;
            state_d = PREP;
          end else if (op == MTHI) begin
            hi_d = op_a;
          end else if (op == MTLO) begin
            lo_d = op_a;
          end
        end
      end
      PREP: begin
        quot_neg_d = op_signed && (a_q[WIDTH-1] ^ opnd_q[WIDTH-1]);
        rem_neg_d  = op_signed && a_q[WIDTH-1];
        // Multiply keeps the multiplier in the accumulator and adds the
        // multiplicand; divide shifts the dividend out against the divisor.
        if (op_div) begin
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          opnd_d = b_mag;
        end else begin
          acc_d  = {{WIDTH{1'b0}}, b_mag};
          opnd_d = a_mag;
        end
        cnt_d   = CNT_LOAD;
        state_d = RUN;
      end
      RUN: begin
        acc_d = chain[ITER_PER_CYCLE];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIX;
      end
      FIX: begin
        if (op_div) begin
          // |b| == 0 exactly when b == 0, so the operand register still tells.
          if (opnd_q == '0) begin
            hi_d = a_q;
            lo_d = DIV0_LO[WIDTH-1:0];
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= NOP;
      a_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (clock_enable) begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Arithmetic issue while busy is a CPU interlock bug; MTHI/MTLO are
  // silently dropped instead.
  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(clock_enable && start && busy_q && is_arith(op)))
    else $error("arithmetic op issued while busy");

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clock_enable;
  logic        start;
  md_op_t      op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32), .ITER_PER_CYCLE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .clock_enable (clock_enable),
    .start        (start),
    .op           (op),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    h = '0;
    l = '0;
    case (o)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
      end
      MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        {h, l} = up;
      end
      DIV: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 32'h0; end
        else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
      end
      DIVU: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issues one arithmetic op and observes it; callers do the comparisons.
  // lat = enabled-or-stalled edges after the accept edge until done is seen
  // (-1 on timeout). busy_cnt counts sampled cycles with busy high.
  task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input int mt_at, input bit stretch,
                        output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat,
                        output int busy_cnt, output bit held, output logic done_stretch,
                        output logic done_after);
    logic [31:0] h0, l0;
    int total;
    bit seen;
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op = NOP;
    total = 0; busy_cnt = 0; held = 1'b1; seen = 1'b0;
    while (total < 300) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (stall_len > 0 && total == stall_at) clock_enable = 1'b0;
      if (stall_len > 0 && total == stall_at + stall_len) clock_enable = 1'b1;
      if (total == mt_at) begin start = 1'b1; op = MTLO; op_a = 32'hDEAD_BEEF; end
      if (total == mt_at + 1) begin start = 1'b0; op = NOP; end
      @(negedge clk);
      total++;
    end
    clock_enable = 1'b1;
    start = 1'b0; op = NOP;
    lat = seen ? total : -1;
    hi_o = hi; lo_o = lo;
    done_stretch = done;
    if (stretch) begin
      clock_enable = 1'b0;
      repeat (3) @(negedge clk);
      done_stretch = done;
      clock_enable = 1'b1;
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; clock_enable = 1'b1; start = 1'b0; op = NOP; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = MTHI; op_a = 32'h1234;
    @(negedge clk);
    vectors++; if (hi !== 32'h1234 || done !== 1'b0) begin miscompares++; $display("FAIL mthi: got hi=%h done=%b want hi=00001234 done=0", hi, done); end
    op = MTLO; op_a = 32'h5678;
    @(negedge clk);
    vectors++; if (lo !== 32'h5678 || hi !== 32'h1234 || done !== 1'b0) begin miscompares++; $display("FAIL mtlo: got hi=%h lo=%h done=%b want 00001234 00005678 0", hi, lo, done); end
    op = NOP; op_a = 32'hFFFF;
    @(negedge clk);
    vectors++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin miscompares++; $display("FAIL nop: got hi=%h lo=%h busy=%b", hi, lo, busy); end
    start = 1'b0;
  endtask

  typedef struct {
    md_op_t      o;
    logic [31:0] a, b, h, l;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [7];
    logic [31:0] h, l, mh, ml;
    int lat, bc;
    bit held;
    logic ds, da;
    tbl[0] = '{MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[1] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{DIVU,  32'h7,         32'h2,         32'h1,         32'h3};
    tbl[4] = '{DIVU,  32'd100,       32'h0,         32'h0000_0064, 32'hFFFF_FFFF};
    tbl[5] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    tbl[6] = '{DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      mh = hi; ml = lo;
      run_op(tbl[i].o, tbl[i].a, tbl[i].b, -1, 0, -100, 1'b0, h, l, lat, bc, held, ds, da);
      vectors++; if (h !== tbl[i].h || l !== tbl[i].l) begin miscompares++; $display("FAIL directed[%0d] result: got hi=%h lo=%h want hi=%h lo=%h", i, h, l, tbl[i].h, tbl[i].l); end
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL directed[%0d] latency: got %0d want 34", i, lat); end
      vectors++; if (bc !== 34) begin miscompares++; $display("FAIL directed[%0d] busy_cycles: got %0d want 34", i, bc); end
      vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL directed[%0d] hold: hi/lo changed before done (was %h/%h)", i, mh, ml); end
      vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL directed[%0d] done_pulse: got %b after pulse want 0", i, da); end
    end
  endtask

  task automatic test_mt_while_busy();
    logic [31:0] h, l, mh, ml;
    int lat, bc;
    bit held;
    logic ds, da;
    model(MULTU, 32'h0001_0003, 32'h0000_0101, mh, ml);
    run_op(MULTU, 32'h0001_0003, 32'h0000_0101, -1, 0, 10, 1'b0, h, l, lat, bc, held, ds, da);
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL mt_busy_hold: lo changed while busy"); end
    vectors++; if (h !== mh || l !== ml) begin miscompares++; $display("FAIL mt_busy_result: got %h/%h want %h/%h", h, l, mh, ml); end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, h, l, mh, ml;
    int lat, bc;
    bit held;
    logic ds, da;
    a = $urandom; b = $urandom | 32'h1;
    model(DIV, a, b, mh, ml);
    run_op(DIV, a, b, 10, 10, -100, 1'b1, h, l, lat, bc, held, ds, da);
    vectors++; if (lat !== 44) begin miscompares++; $display("FAIL stall_latency: got %0d want 44", lat); end
    vectors++; if (h !== mh || l !== ml) begin miscompares++; $display("FAIL stall_result: got %h/%h want %h/%h", h, l, mh, ml); end
    vectors++; if (ds !== 1'b1) begin miscompares++; $display("FAIL done_stretch: got %b want 1", ds); end
    vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL done_drop: got %b want 0", da); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, h, l, mh, ml;
    int lat, bc, k, sel;
    bit held;
    logic ds, da;
    md_op_t o;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) b = $urandom_range(1, 20);
      else if (sel == 2) b = -($urandom_range(1, 20));
      else if (sel == 3) a = 32'h8000_0000;
      if (k >= 4) begin
        mh = hi; ml = lo;
        start = 1'b1; op = (k == 4) ? MTHI : MTLO; op_a = a;
        @(negedge clk);
        start = 1'b0; op = NOP;
        if (k == 4) mh = a; else ml = a;
        vectors++; if (hi !== mh || lo !== ml || done !== 1'b0) begin miscompares++; $display("FAIL random[%0d] mt: got %h/%h done=%b want %h/%h", i, hi, lo, done, mh, ml); end
      end else begin
        o = md_op_t'(k + 1);
        model(o, a, b, mh, ml);
        run_op(o, a, b, -1, 0, -100, 1'b0, h, l, lat, bc, held, ds, da);
        vectors++; if (h !== mh || l !== ml || lat !== 34) begin miscompares++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h/%h lat=%0d want %h/%h lat=34", i, k + 1, a, b, h, l, lat, mh, ml); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    start = 1'b1; op = MTHI; op_a = 32'hAAAA_0001;
    @(negedge clk);
    op = MTLO; op_a = 32'h5555_0002;
    @(negedge clk);
    op = DIVU; op_a = 32'h1234_5678; op_b = 32'h77;
    @(negedge clk);
    start = 1'b0; op = NOP;
    repeat (16) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_mid_pre_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL reset_mid_hilo: got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL reset_mid_no_done: got activity after reset want none"); end
    vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin miscompares++; $display("FAIL reset_mid_hilo_after: got %h/%h want 0/0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_mt_while_busy();
    test_stall();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1);
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the Harvard CPU.
- Sits directly downstream of the CPU decode/register-read logic:
  - The CPU issues MULT/MULTU/DIV/DIVU/MTHI/MTLO with rs/rt operands.
  - The CPU stalls on busy.
  - The CPU reads hi/lo combinationally for MFHI/MFLO.
- Replaces single-cycle HI/LO arithmetic with a shift-add/restoring-divide datapath so timing closes at the core clock.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
- ITER_PER_CYCLE, 1, radix steps per RUN cycle; legal values are 1 and 2; WIDTH must be divisible by it.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clock_enable  input  1  when low, all state holds; only enabled edges count toward latency.
- start  input  1  request strobe, sampled on enabled edges.
- op  input  3  operation code (mips_muldiv_pkg::md_op_t).
- op_a  input  WIDTH  rs value (dividend, multiplicand, or MTHI/MTLO source).
- op_b  input  WIDTH  rt value (divisor, multiplier).
- busy  output  1  high while an arithmetic op is in flight.
- done  output  1  one-cycle pulse; HI/LO already hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Counter and datapath registers cleared.
  - Reset mid-operation aborts the op; no partial HI/LO write.
- FSM states IDLE -> PREP -> RUN -> FIX -> IDLE. All transitions occur only on edges with clock_enable=1.
- IDLE:
  - start=1 with op in {MULT,MULTU,DIV,DIVU}: latch operands and op, busy<=1, go to PREP.
  - start=1 with op=MTHI: hi<=op_a, done stays 0, stay in IDLE. MTLO likewise writes lo.
  - op=NOP, or start=0: no effect.
- PREP (1 cycle):
  - Signed ops: take magnitudes |a| and |b|; record neg_q = a[msb]^b[msb] and neg_r = a[msb].
  - Unsigned ops: pass operands through; neg_q = neg_r = 0.
  - Load counter = WIDTH/ITER_PER_CYCLE.
- RUN (WIDTH/ITER_PER_CYCLE cycles):
  - Multiply: unsigned shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division into a remainder/quotient pair.
  - Counter decrements each cycle; go to FIX when it reaches 1.
- FIX (1 cycle):
  - Multiply: negate the 2*WIDTH product if neg_q; hi<=product[2W-1:W], lo<=product[W-1:0].
  - Divide: lo<=quotient, negated if neg_q; hi<=remainder, negated if neg_r.
  - busy<=0, done<=1, go to IDLE.
- done drops on the next enabled edge.
- Latency at WIDTH=32, ITER=1: accepted at enabled edge E0, result and done visible after enabled edge E0+34.
- Divide by zero (op_b=0), DIV or DIVU: result is hi=op_a (original, unsigned view) and lo=all-ones. Sign fix is skipped. Latency is unchanged.
- Signed overflow, DIV 0x80000000 / -1: lo=0x80000000, hi=0, i.e. modular wrap with no exception.
- Behaviour while busy:
  - start is ignored; the CPU must not issue. An assertion flags start while busy.
  - MTHI/MTLO are also ignored.
- clock_enable=0 in any state: freezes FSM, counter, and outputs; a done pulse is stretched until the next enabled edge.
- hi/lo outputs hold their old values throughout an operation until the FIX edge.

Decomposition:
- Package mips_muldiv_pkg holds:
  - md_op_t enum (3 bits): NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - md_state_t enum: IDLE, PREP, RUN, FIX.
  - Localparam DIV0_LO = all-ones.
- One natural sub-module, mips_muldiv_step: combinational single radix step.
  - Inputs: mode mul/div, accumulator/remainder, operand.
  - Output: next accumulator/remainder.
  - Instantiated ITER_PER_CYCLE times in a chain inside RUN.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 -> after 34 enabled edges: done pulses 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 34 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Side-effect ops:
  - MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi=0x1234 and lo=0x5678 on successive edges, no done.
  - MTLO issued while busy -> lo unchanged until FIX.
- Stall and reset:
  - Drop clock_enable for 10 cycles mid-RUN -> done arrives 10 cycles later with a correct result.
  - Assert reset at RUN cycle 15 -> busy=0, hi=lo=0 immediately; no done afterwards.
